// File: rtl/crc_16_chk_pkg.sv
// Sideband CRC-16 shared definitions: symbol framing, polynomial/seed and checker FSM states.
// Shared between the RX checker and the TX generator.
package sb_crc_pkg;

  localparam int unsigned SB_SYM_BITS  = 10;
  localparam logic        SB_START_BIT = 1'b0;
  localparam logic        SB_STOP_BIT  = 1'b1;
  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam int unsigned CRC16_SYMS   = 2;

  typedef logic [3:0] bit_cnt_t;
  localparam bit_cnt_t SB_LAST_BIT = bit_cnt_t'(SB_SYM_BITS - 1);

  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} crc_state_t;
  typedef enum logic {LFSR_CALC, LFSR_DRAIN} lfsr_mode_t;

endpackage

// File: rtl/crc_16_chk_if.sv
// Sideband CRC checker interface; master drives the framed stream, slave is the checker.
// CRC_CHK_ERR_CNT_EN adds the saturating error counter signal.
interface crc_16_chk_if;

  logic chk_en;
  logic crc_phase;
  logic rec_ser;
  logic busy;
  logic crc_ok;
  logic crc_err;
  logic frame_err;

`ifdef CRC_CHK_ERR_CNT_EN
  logic [7:0] err_cnt;

  modport master (output chk_en, crc_phase, rec_ser,
                  input  busy, crc_ok, crc_err, frame_err, err_cnt);
  modport slave  (input  chk_en, crc_phase, rec_ser,
                  output busy, crc_ok, crc_err, frame_err, err_cnt);
`else
  modport master (output chk_en, crc_phase, rec_ser,
                  input  busy, crc_ok, crc_err, frame_err);
  modport slave  (input  chk_en, crc_phase, rec_ser,
                  output busy, crc_ok, crc_err, frame_err);
`endif

endinterface

// File: rtl/crc_16_chk_lfsr.sv
// Serial CRC-16 LFSR: CALC folds data bits into the remainder, DRAIN shifts it out MSB-first.
// Shared with the TX generator.
module sb_crc16_lfsr
  import sb_crc_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY,
  parameter logic [15:0] INIT = CRC16_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        shift_en,
  input  lfsr_mode_t  mode,
  input  logic        din,
  output logic [15:0] lfsr
);

  logic fb;

  always_comb fb = lfsr[15] ^ din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= INIT;
    end else if (init) begin
      lfsr <= INIT;
    end else if (shift_en) begin
      if (mode == LFSR_CALC) lfsr <= {lfsr[14:0], 1'b0} ^ (fb ? POLY : '0);
      else                   lfsr <= {lfsr[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc_16_chk.sv
// Sideband RX CRC-16 checker: framing counters and FSM around the shared LFSR.
// Optional `CRC_CHK_ERR_CNT_EN adds a saturating count of crc_err pulses.
module crc_16_chk
  import sb_crc_pkg::*;
#(
  parameter logic [15:0] POLY     = CRC16_POLY,
  parameter logic [15:0] INIT     = CRC16_INIT,
  parameter int unsigned CRC_SYMS = CRC16_SYMS
) (
  input  logic          sb_clk,
  input  logic          rst,
  crc_16_chk_if.slave   chk
);

  localparam int unsigned SYM_W = $clog2(CRC_SYMS + 1);

  crc_state_t       state;
  bit_cnt_t         bit_cnt;
  logic [SYM_W-1:0] sym_cnt;
  logic             mism;
  logic             reported;
  logic             crc_ok;
  logic             crc_err;
  logic             frame_err;
  logic             in_frame;
  logic             data_bit;
  logic             lfsr_init;
  logic             lfsr_shift;
  lfsr_mode_t       lfsr_mode;
  logic [15:0]      lfsr;
  logic             lfsr_low_unused;

  always_comb begin
    in_frame   = (state == DATA) || (state == CRC);
    data_bit   = (bit_cnt != '0) && (bit_cnt != SB_LAST_BIT);
    lfsr_init  = (state == IDLE) || !chk.chk_en;
    lfsr_shift = chk.chk_en && in_frame && data_bit;
    lfsr_mode  = (state == CRC) ? LFSR_DRAIN : LFSR_CALC;
  end

  sb_crc16_lfsr #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_lfsr (
    .clk      (sb_clk),
    .rst      (rst),
    .init     (lfsr_init),
    .shift_en (lfsr_shift),
    .mode     (lfsr_mode),
    .din      (chk.rec_ser),
    .lfsr     (lfsr)
  );

  // Only the MSB is compared against the received CRC bits.
  assign lfsr_low_unused = ^lfsr[14:0];

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sym_cnt   <= '0;
      mism      <= 1'b0;
      reported  <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      crc_ok  <= 1'b0;
      crc_err <= 1'b0;
      case (state)
        IDLE: begin
          if (chk.chk_en) begin
            // This cycle carries the first start bit, so it is framing-checked too.
            state     <= chk.crc_phase ? CRC : DATA;
            bit_cnt   <= bit_cnt_t'(1);
            sym_cnt   <= '0;
            mism      <= 1'b0;
            reported  <= 1'b0;
            frame_err <= (chk.rec_ser != SB_START_BIT);
          end
        end
        DATA, CRC: begin
          if (!chk.chk_en) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sym_cnt <= '0;
            mism    <= 1'b0;
          end else begin
            bit_cnt <= (bit_cnt == SB_LAST_BIT) ? '0 : bit_cnt + 4'd1;
            if (bit_cnt == '0 && chk.rec_ser != SB_START_BIT) frame_err <= 1'b1;
            if (bit_cnt == SB_LAST_BIT && chk.rec_ser != SB_STOP_BIT) frame_err <= 1'b1;
            if (state == DATA && bit_cnt == '0 && chk.crc_phase) state <= CRC;
            if (state == CRC && data_bit && chk.rec_ser != lfsr[15]) mism <= 1'b1;
            if (state == CRC && bit_cnt == SB_LAST_BIT) begin
              sym_cnt <= sym_cnt + 1'b1;
              if (sym_cnt == SYM_W'(CRC_SYMS - 1)) state <= DONE;
            end
          end
        end
        DONE: begin
          if (!reported) begin
            reported <= 1'b1;
            crc_ok   <= ~(mism | frame_err);
            crc_err  <= mism | frame_err;
          end
          if (!chk.chk_en) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sym_cnt <= '0;
            mism    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign chk.busy      = (state != IDLE);
  assign chk.crc_ok    = crc_ok;
  assign chk.crc_err   = crc_err;
  assign chk.frame_err = frame_err;

`ifdef CRC_CHK_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst)                        err_cnt <= '0;
    else if (crc_err && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
  end

  assign chk.err_cnt = err_cnt;
`endif

endmodule

// File: tb/tb_crc_16_chk.sv
// Scoreboard bench for crc_16_chk: framed frames driven bit-serially, results checked on pulse.
module tb_crc_16_chk;
  import sb_crc_pkg::*;

  typedef struct {
    logic ok;
    logic err;
    logic ferr;
  } exp_t;

  logic sb_clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sbq[$];
  logic [7:0] exp_err_cnt;

  crc_16_chk_if bus ();

  crc_16_chk #(
    .POLY     (16'h8005),
    .INIT     (16'hFFFF),
    .CRC_SYMS (2)
  ) dut (
    .sb_clk (sb_clk),
    .rst    (rst),
    .chk    (bus)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  task automatic tick();
    @(posedge sb_clk);
    #1;
  endtask

  function automatic logic [15:0] crc_model(input logic [7:0] pl[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pl[k]) begin
      c = c ^ {pl[k], 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    end
    return c;
  endfunction

  // abort_at: bit index where the frame is cut (-1 none); abort_rst selects rst instead of chk_en drop.
  task automatic run_frame(input string name, input logic [7:0] pl[$], input logic [7:0] c0,
                           input logic [7:0] c1, input int bad_stop_sym, input int abort_at,
                           input bit abort_rst);
    logic [7:0] syms[$];
    logic       bits[$];
    logic       ph[$];
    logic [7:0] d;
    int         stop_idx;
    int         lat;
    bit         seen;
    exp_t       e;
    syms = pl;
    syms.push_back(c0);
    syms.push_back(c1);
    stop_idx = -1;
    foreach (syms[s]) begin
      d = syms[s];
      for (int b = 0; b < 10; b++) begin
        if (b == 0)      bits.push_back(1'b0);
        else if (b == 9) bits.push_back((s == bad_stop_sym) ? 1'b0 : 1'b1);
        else             bits.push_back(d[8-b]);
        ph.push_back(s >= pl.size());
      end
      if (s == bad_stop_sym) stop_idx = s * 10 + 9;
    end
    if (abort_at < 0) begin
      e.ok   = (crc_model(pl) == {c0, c1}) && (bad_stop_sym < 0);
      e.err  = !e.ok;
      e.ferr = (bad_stop_sym >= 0);
      sbq.push_back(e);
      if (e.err && exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
    end
    for (int i = 0; i < bits.size(); i++) begin
      if (i == abort_at) break;
      bus.chk_en    = 1'b1;
      bus.rec_ser   = bits[i];
      bus.crc_phase = ph[i];
      tick();
      total++;
      if (bus.crc_ok !== 1'b0 || bus.crc_err !== 1'b0) begin
        bad++;
        $display("FAIL %s early_pulse bit=%0d ok=%b err=%b required 0 0", name, i, bus.crc_ok, bus.crc_err);
      end
      if (i == 0) begin
        total++;
        if (bus.busy !== 1'b1 || bus.frame_err !== 1'b0) begin
          bad++;
          $display("FAIL %s frame_start busy=%b frame_err=%b required 1 0", name, bus.busy, bus.frame_err);
        end
      end
      if (i == stop_idx) begin
        total++;
        if (bus.frame_err !== 1'b1) begin
          bad++;
          $display("FAIL %s frame_err_set got=%b required 1", name, bus.frame_err);
        end
      end
    end
    if (abort_at >= 0 && abort_rst) begin
      rst = 1'b0;
      #2;
      exp_err_cnt = 8'h00;
      total++;
      if ({bus.busy, bus.crc_ok, bus.crc_err, bus.frame_err} !== 4'b0000) begin
        bad++;
        $display("FAIL %s reset_mid busy/ok/err/ferr=%b required 0000", name,
                 {bus.busy, bus.crc_ok, bus.crc_err, bus.frame_err});
      end
`ifdef CRC_CHK_ERR_CNT_EN
      total++;
      if (bus.err_cnt !== 8'h00) begin
        bad++;
        $display("FAIL %s reset_err_cnt got=%0d required 0", name, bus.err_cnt);
      end
`endif
      bus.chk_en    = 1'b0;
      bus.crc_phase = 1'b0;
      bus.rec_ser   = 1'b0;
      tick();
      rst = 1'b1;
      tick();
    end else if (abort_at >= 0) begin
      bus.chk_en    = 1'b0;
      bus.crc_phase = 1'b0;
      tick();
      total++;
      if (bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL %s abort_busy got=%b required 0", name, bus.busy);
      end
      repeat (3) begin
        tick();
        total++;
        if (bus.crc_ok !== 1'b0 || bus.crc_err !== 1'b0) begin
          bad++;
          $display("FAIL %s abort_pulse ok=%b err=%b required 0 0", name, bus.crc_ok, bus.crc_err);
        end
      end
    end else begin
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < 4) begin
        tick();
        lat++;
        seen = (bus.crc_ok === 1'b1) || (bus.crc_err === 1'b1);
      end
      total++;
      if (!seen || lat != 1) begin
        bad++;
        $display("FAIL %s latency seen=%b cycles=%0d required 1", name, seen, lat);
      end
      e = sbq.pop_front();
      if (seen) begin
        total++;
        if (bus.crc_ok !== e.ok || bus.crc_err !== e.err || bus.frame_err !== e.ferr) begin
          bad++;
          $display("FAIL %s result ok/err/ferr=%b%b%b required %b%b%b", name, bus.crc_ok,
                   bus.crc_err, bus.frame_err, e.ok, e.err, e.ferr);
        end
      end
      tick();
      total++;
      if (bus.crc_ok !== 1'b0 || bus.crc_err !== 1'b0 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL %s done_hold ok=%b err=%b busy=%b required 0 0 1", name, bus.crc_ok,
                 bus.crc_err, bus.busy);
      end
`ifdef CRC_CHK_ERR_CNT_EN
      total++;
      if (bus.err_cnt !== exp_err_cnt) begin
        bad++;
        $display("FAIL %s err_cnt got=%0d required %0d", name, bus.err_cnt, exp_err_cnt);
      end
`endif
      bus.chk_en    = 1'b0;
      bus.crc_phase = 1'b0;
      tick();
      total++;
      if (bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL %s release_busy got=%b required 0", name, bus.busy);
      end
    end
  endtask

  task automatic check_vector(input logic [7:0] pl[$]);
    pl.delete();
    for (int k = 0; k < 9; k++) pl.push_back(8'(8'h31 + k));
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.chk_en    = 1'b0;
    bus.crc_phase = 1'b0;
    bus.rec_ser   = 1'b0;
    repeat (2) tick();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b required 0", bus.busy); end
    total++;
    if (bus.crc_ok !== 1'b0) begin bad++; $display("FAIL reset_ok got=%b required 0", bus.crc_ok); end
    total++;
    if (bus.crc_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b required 0", bus.crc_err); end
    total++;
    if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b required 0", bus.frame_err); end
`ifdef CRC_CHK_ERR_CNT_EN
    total++;
    if (bus.err_cnt !== 8'h00) begin bad++; $display("FAIL reset_err_cnt got=%0d required 0", bus.err_cnt); end
`endif
    rst = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    logic [7:0] pl[$];
    for (int k = 0; k < 9; k++) pl.push_back(8'(8'h31 + k));
    run_frame("good", pl, 8'hAE, 8'hE7, -1, -1, 1'b0);
  endtask

  task automatic test_bad_crc();
    logic [7:0] pl[$];
    for (int k = 0; k < 9; k++) pl.push_back(8'(8'h31 + k));
    run_frame("bad_crc", pl, 8'hAE, 8'hE6, -1, -1, 1'b0);
  endtask

  task automatic test_framing();
    logic [7:0] pl[$];
    for (int k = 0; k < 9; k++) pl.push_back(8'(8'h31 + k));
    run_frame("framing", pl, 8'hAE, 8'hE7, 2, -1, 1'b0);
  endtask

  task automatic test_abort();
    logic [7:0] pl[$];
    for (int k = 0; k < 9; k++) pl.push_back(8'(8'h31 + k));
    run_frame("abort5", pl, 8'hAE, 8'hE7, -1, 50, 1'b0);
    run_frame("after_abort", pl, 8'hAE, 8'hE7, -1, -1, 1'b0);
    run_frame("abort_last_stop", pl, 8'hAE, 8'hE7, -1, 109, 1'b0);
    run_frame("after_last_abort", pl, 8'hAE, 8'hE7, -1, -1, 1'b0);
  endtask

  task automatic test_empty_payload();
    logic [7:0] pl[$];
    run_frame("empty_ff", pl, 8'hFF, 8'hFF, -1, -1, 1'b0);
    run_frame("empty_bad", pl, 8'hFF, 8'hFE, -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] pl[$];
    for (int k = 0; k < 9; k++) pl.push_back(8'(8'h31 + k));
    run_frame("rst_mid", pl, 8'hAE, 8'hE7, -1, 93, 1'b1);
    run_frame("after_rst", pl, 8'hAE, 8'hE7, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pl[$];
    logic [15:0] c;
    for (int f = 0; f < 8; f++) begin
      pl.delete();
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) pl.push_back(8'($urandom));
      c = crc_model(pl);
      if ($urandom_range(0, 1) == 1) c = c ^ (16'h0001 << $urandom_range(0, 15));
      run_frame("b2b", pl, c[15:8], c[7:0], -1, -1, 1'b0);
    end
  endtask

`ifdef CRC_CHK_ERR_CNT_EN
  task automatic test_err_cnt_sat();
    logic [7:0] pl[$];
    for (int f = 0; f < 256; f++) run_frame("sat", pl, 8'h00, 8'h00, -1, -1, 1'b0);
    total++;
    if (bus.err_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL err_cnt_sat got=%0d required 255", bus.err_cnt);
    end
  endtask
`endif

  initial begin
    total       = 0;
    bad         = 0;
    exp_err_cnt = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_framing();
    test_abort();
    test_empty_payload();
    test_reset_mid();
    test_back_to_back();
`ifdef CRC_CHK_ERR_CNT_EN
    test_err_cnt_sat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
